exe_mem_reg: RTL and testbench
==============================

EXE_MEM_REG -- requirements
Module: exe_mem_reg

Interface
REQ-001 Parameters: none; all widths fixed (32-bit data, 4-bit register index, 4-bit status {N,Z,C,V}).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 valid_in  in  1  EXE-stage output holds a real instruction; 0 = bubble.
REQ-006 WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, S_in  in  1 each  writeback, load, store and status-update controls from EXE.
REQ-007 ALU_Res_in  in  32  ALU result, used as data address for loads and stores.
REQ-008 status_in  in  4  ALU {N,Z,C,V} flags.
REQ-009 Val_Rm_in  in  32  store data, already forwarded.
REQ-010 Dest_in  in  4  destination register index.
REQ-011 mem_ready  in  1  SRAM controller has completed the outstanding access.
REQ-012 valid_out, WB_EN, MEM_R_EN, MEM_W_EN  out  1 each  registered controls to MEM.
REQ-013 ALU_Res, Val_Rm  out  32 each; Dest  out  4  registered data to MEM.
REQ-014 SR  out  4  architectural status register, fed back to EXE as Cin source (SR[1] = C).
REQ-015 mem_req  out  1  registered; access pending toward SRAM controller.
REQ-016 freeze  out  1  combinational stall to all upstream stages and the forwarding unit.
REQ-017 wait_cnt  out  8  saturating count of freeze cycles since reset.

Function
REQ-018 FSM has two states: IDLE and WAIT.
REQ-019 IDLE, every edge: capture all *_in into the output registers; when valid_in=0, WB_EN, MEM_R_EN, MEM_W_EN and valid_out load 0; data fields still load.
REQ-020 IDLE -> WAIT on the edge that captures valid_in=1 with (MEM_R_EN_in | MEM_W_EN_in)=1; otherwise stay in IDLE.
REQ-021 mem_req = 1 exactly while state = WAIT.
REQ-022 WAIT: all output registers and SR hold their values.
REQ-023 freeze = (state == WAIT) & ~mem_ready.
REQ-024 WAIT with mem_ready=1: on that edge, capture new inputs as in IDLE (freeze=0, so upstream advances on the same edge); next state follows REQ-020 for the newly captured instruction, giving back-to-back memory ops with no IDLE cycle.
REQ-025 WAIT with mem_ready=0: stay in WAIT.
REQ-026 mem_ready while IDLE is ignored.
REQ-027 SR loads status_in on any capturing edge (non-frozen) where valid_in=1 and S_in=1; otherwise SR holds. A frozen edge never updates SR.
REQ-028 wait_cnt increments by 1 on every edge where freeze=1 and saturates at 255.
REQ-029 Minimum latency is 1 cycle from input to output; a memory op stalls upstream until the cycle mem_ready is seen.

Reset
REQ-030 While rst=1: state = IDLE and all registered outputs are 0, so SR=4'b0000, mem_req=0, freeze=0 and wait_cnt=0.
REQ-031 rst asserted in WAIT aborts the access: mem_req drops asynchronously and the captured instruction is discarded.
REQ-032 First capture occurs on the first rising edge after rst deasserts.

Verification
REQ-033 ALU op: valid_in=1, WB_EN_in=1, S_in=1, ALU_Res_in=32'h5, status_in=4'b0010 -> next cycle ALU_Res=5, WB_EN=1, SR=0010, freeze=0.
REQ-034 Load with mem_ready held 0 for 3 cycles, then 1 -> mem_req high 4 cycles, freeze high 3 cycles, outputs stable throughout, wait_cnt=3.
REQ-035 Two consecutive stores, mem_ready=1 in the first WAIT cycle -> second store captured on that edge, state stays WAIT, mem_req continuously high.
REQ-036 Bubble: valid_in=0 with WB_EN_in=1, S_in=1 -> WB_EN=0, valid_out=0, SR unchanged.
REQ-037 S_in=1 instruction presented while frozen -> SR unchanged until the capturing edge, then SR=status_in.
REQ-038 rst pulse mid-WAIT -> mem_req=0, SR=0, all enables 0 immediately, state IDLE.

Source files
------------

// File: rtl/exe_mem_reg.sv
// EXE/MEM pipeline register with SRAM handshake: holds a load/store in WAIT
// until mem_ready, stalling upstream and owning the architectural status register.
module exe_mem_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic        WB_EN_in,
   input  logic        MEM_R_EN_in,
   input  logic        MEM_W_EN_in,
   input  logic        S_in,
   input  logic [31:0] ALU_Res_in,
   input  logic [3:0]  status_in,
   input  logic [31:0] Val_Rm_in,
   input  logic [3:0]  Dest_in,
   input  logic        mem_ready,
   output logic        valid_out,
   output logic        WB_EN,
   output logic        MEM_R_EN,
   output logic        MEM_W_EN,
   output logic [31:0] ALU_Res,
   output logic [31:0] Val_Rm,
   output logic [3:0]  Dest,
   output logic [3:0]  SR,
   output logic        mem_req,
   output logic        freeze,
   output logic [7:0]  wait_cnt
);

   typedef enum logic [0:0] {IDLE, WAIT} state_t;

   state_t state, state_nxt;
   logic   capture;
   logic   is_mem_op;

   assign capture   = ~freeze;
   assign is_mem_op = valid_in & (MEM_R_EN_in | MEM_W_EN_in);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // A completing access in WAIT captures the next instruction on the same
   // edge, so a following memory op re-enters WAIT with no IDLE gap.
   always_comb begin
      state_nxt = state;
      if (capture) state_nxt = is_mem_op ? WAIT : IDLE;
   end

   always_comb begin
      mem_req = (state == WAIT);
      freeze  = (state == WAIT) & ~mem_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         WB_EN     <= 1'b0;
         MEM_R_EN  <= 1'b0;
         MEM_W_EN  <= 1'b0;
         ALU_Res   <= '0;
         Val_Rm    <= '0;
         Dest      <= '0;
         SR        <= '0;
      end else if (capture) begin
         valid_out <= valid_in;
         WB_EN     <= valid_in & WB_EN_in;
         MEM_R_EN  <= valid_in & MEM_R_EN_in;
         MEM_W_EN  <= valid_in & MEM_W_EN_in;
         ALU_Res   <= ALU_Res_in;
         Val_Rm    <= Val_Rm_in;
         Dest      <= Dest_in;
         if (valid_in & S_in) SR <= status_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             wait_cnt <= '0;
      else if (freeze && wait_cnt != '1)   wait_cnt <= wait_cnt + 8'd1;
   end

endmodule

// File: tb/tb_exe_mem_reg.sv
// Directed self-checking bench for exe_mem_reg: ALU ops, bubbles, stalled
// loads, back-to-back stores, async reset mid-access and wait_cnt saturation.
module tb_exe_mem_reg;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in, WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, S_in;
   logic [31:0] ALU_Res_in, Val_Rm_in;
   logic [3:0]  status_in, Dest_in;
   logic        mem_ready;
   logic        valid_out, WB_EN, MEM_R_EN, MEM_W_EN;
   logic [31:0] ALU_Res, Val_Rm;
   logic [3:0]  Dest, SR;
   logic        mem_req, freeze;
   logic [7:0]  wait_cnt;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   exe_mem_reg dut (
      .clk(clk), .rst(rst),
      .valid_in(valid_in), .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in),
      .MEM_W_EN_in(MEM_W_EN_in), .S_in(S_in), .ALU_Res_in(ALU_Res_in),
      .status_in(status_in), .Val_Rm_in(Val_Rm_in), .Dest_in(Dest_in),
      .mem_ready(mem_ready),
      .valid_out(valid_out), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .ALU_Res(ALU_Res), .Val_Rm(Val_Rm), .Dest(Dest), .SR(SR),
      .mem_req(mem_req), .freeze(freeze), .wait_cnt(wait_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic wb, input logic mr, input logic mw,
                        input logic s, input logic [31:0] res, input logic [3:0] st,
                        input logic [31:0] rm, input logic [3:0] dst);
      valid_in = v; WB_EN_in = wb; MEM_R_EN_in = mr; MEM_W_EN_in = mw; S_in = s;
      ALU_Res_in = res; status_in = st; Val_Rm_in = rm; Dest_in = dst;
   endtask

   initial begin
      rst = 1'b1;
      mem_ready = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
      repeat (3) tick();
      check("rst_valid_out", {31'd0, valid_out}, 32'd0);
      check("rst_sr", {28'd0, SR}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_freeze", {31'd0, freeze}, 32'd0);
      check("rst_wait_cnt", {24'd0, wait_cnt}, 32'd0);
      check("rst_alu_res", ALU_Res, 32'd0);
      rst = 1'b0;

      // ALU op with status update
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h5, 4'b0010, 32'h0, 4'h3);
      tick();
      check("alu_res", ALU_Res, 32'h5);
      check("alu_wb_en", {31'd0, WB_EN}, 32'd1);
      check("alu_valid_out", {31'd0, valid_out}, 32'd1);
      check("alu_sr", {28'd0, SR}, 32'h2);
      check("alu_dest", {28'd0, Dest}, 32'h3);
      check("alu_freeze", {31'd0, freeze}, 32'd0);
      check("alu_mem_req", {31'd0, mem_req}, 32'd0);

      // bubble: controls squashed, data still loads, SR kept, no memory access
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h7, 4'hF, 32'h0, 4'h9);
      tick();
      check("bub_wb_en", {31'd0, WB_EN}, 32'd0);
      check("bub_valid_out", {31'd0, valid_out}, 32'd0);
      check("bub_mem_r_en", {31'd0, MEM_R_EN}, 32'd0);
      check("bub_sr", {28'd0, SR}, 32'h2);
      check("bub_alu_res", ALU_Res, 32'h7);
      check("bub_mem_req", {31'd0, mem_req}, 32'd0);

      // load stalled three cycles; S_in instruction waits behind it
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd100, 4'h0, 32'h0, 4'h5);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd200, 4'b1000, 32'h0, 4'h6);
      for (int i = 0; i < 3; i++) begin
         check("ld_mem_req", {31'd0, mem_req}, 32'd1);
         check("ld_freeze", {31'd0, freeze}, 32'd1);
         check("ld_alu_res_hold", ALU_Res, 32'd100);
         check("ld_mem_r_en_hold", {31'd0, MEM_R_EN}, 32'd1);
         check("ld_dest_hold", {28'd0, Dest}, 32'h5);
         check("ld_sr_hold", {28'd0, SR}, 32'h2);
         check("ld_wait_cnt", {24'd0, wait_cnt}, i);
         tick();
      end
      mem_ready = 1'b1;
      #1;
      check("ld_last_mem_req", {31'd0, mem_req}, 32'd1);
      check("ld_last_freeze", {31'd0, freeze}, 32'd0);
      check("ld_wait_cnt3", {24'd0, wait_cnt}, 32'd3);
      tick();
      check("after_ld_alu_res", ALU_Res, 32'd200);
      check("after_ld_sr", {28'd0, SR}, 32'h8);
      check("after_ld_mem_req", {31'd0, mem_req}, 32'd0);
      check("after_ld_wait_cnt", {24'd0, wait_cnt}, 32'd3);
      check("idle_ready_freeze", {31'd0, freeze}, 32'd0);

      // back-to-back stores
      mem_ready = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 4'h0, 32'hAAAA, 4'h1);
      tick();
      check("st1_mem_req", {31'd0, mem_req}, 32'd1);
      check("st1_val_rm", Val_Rm, 32'hAAAA);
      check("st1_mem_w_en", {31'd0, MEM_W_EN}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 4'h0, 32'hBBBB, 4'h2);
      mem_ready = 1'b1;
      #1;
      check("st1_ready_freeze", {31'd0, freeze}, 32'd0);
      tick();
      check("st2_val_rm", Val_Rm, 32'hBBBB);
      check("st2_alu_res", ALU_Res, 32'h44);
      check("st2_mem_req", {31'd0, mem_req}, 32'd1);
      check("st2_wait_cnt", {24'd0, wait_cnt}, 32'd3);
      mem_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h99, 4'b0100, 32'h0, 4'h7);
      tick();
      check("st2_stall_freeze", {31'd0, freeze}, 32'd1);
      check("st2_stall_cnt", {24'd0, wait_cnt}, 32'd4);

      // async reset mid-WAIT
      #2 rst = 1'b1;
      #1;
      check("arst_mem_req", {31'd0, mem_req}, 32'd0);
      check("arst_sr", {28'd0, SR}, 32'd0);
      check("arst_mem_w_en", {31'd0, MEM_W_EN}, 32'd0);
      check("arst_valid_out", {31'd0, valid_out}, 32'd0);
      check("arst_freeze", {31'd0, freeze}, 32'd0);
      check("arst_wait_cnt", {24'd0, wait_cnt}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_sr", {28'd0, SR}, 32'h4);
      check("post_rst_alu_res", ALU_Res, 32'h99);
      check("post_rst_mem_req", {31'd0, mem_req}, 32'd0);

      // wait_cnt saturation on a long stall
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80, 4'h0, 32'h0, 4'h8);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0);
      repeat (255) tick();
      check("sat_255", {24'd0, wait_cnt}, 32'd255);
      repeat (5) tick();
      check("sat_hold", {24'd0, wait_cnt}, 32'd255);
      check("sat_freeze", {31'd0, freeze}, 32'd1);
      mem_ready = 1'b1;
      tick();
      check("sat_release_mem_req", {31'd0, mem_req}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
